// File: rtl/hdmi_i2c_config_seq.sv
// Configuration sequencer for the HDMI transmitter: after a power-up delay it walks a
// fixed register table and drives one {slave, reg, data} write per entry into the I2C engine.
module hdmi_i2c_config_seq #(
    parameter logic [7:0]  SLAVE_ADDR = 8'h72,
    parameter int unsigned PWRUP_DLY  = 20000,
    parameter int unsigned TIMEOUT    = 4095,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        i_pt_ck,
    input  logic        i_reset,
    input  logic        i_hpd,
    input  logic        i_end_ok,
    input  logic        i_nack,
    output logic        o_go,
    output logic [7:0]  o_slave_address,
    output logic [15:0] o_reg_data,
    output logic [3:0]  o_index,
    output logic [1:0]  o_retry,
    output logic        o_ready,
    output logic        o_error
);
    typedef enum logic [2:0] {
        S_WAIT, S_LOAD, S_GO_HI, S_GO_LO, S_BUSY, S_CHECK, S_DONE, S_FAIL
    } state_t;

    localparam logic [14:0] DLY_LAST   = 15'(PWRUP_DLY - 1);
    localparam logic [11:0] TO_LAST    = 12'(TIMEOUT - 1);
    localparam logic [1:0]  RETRY_MAX  = 2'(MAX_RETRY);
    localparam logic [3:0]  LAST_INDEX = 4'd9;

    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    table_entry = 16'h4110;
            4'd1:    table_entry = 16'h9803;
            4'd2:    table_entry = 16'h9AE0;
            4'd3:    table_entry = 16'h9C30;
            4'd4:    table_entry = 16'h9D61;
            4'd5:    table_entry = 16'hA2A4;
            4'd6:    table_entry = 16'hA3A4;
            4'd7:    table_entry = 16'hE0D0;
            4'd8:    table_entry = 16'hF900;
            4'd9:    table_entry = 16'h1500;
            default: table_entry = 16'h0000;
        endcase
    endfunction

    state_t      r_state;
    logic [14:0] r_dly_cnt;
    logic [11:0] r_to_cnt;
    logic        r_go_cnt;
    logic        r_to_fail;
    logic        r_go;
    logic [15:0] r_reg_data;
    logic [3:0]  r_index;
    logic [1:0]  r_retry;
    logic        r_ready;
    logic        r_error;
    logic        r_hpd_s1;
    logic        r_hpd_s2;
    logic        r_hpd_d;

    logic        w_hpd_rise;
    logic        w_attempt_ok;
    logic [3:0]  w_next_index;

    assign w_hpd_rise   = r_hpd_s2 & ~r_hpd_d;
    assign w_attempt_ok = ~r_to_fail & ~i_nack;
    assign w_next_index = r_index + 4'd1;

    // Two-flop synchroniser for the asynchronous hot-plug input, plus edge history
    always_ff @(posedge i_pt_ck) begin
        if (i_reset) begin
            r_hpd_s1 <= 1'b0;
            r_hpd_s2 <= 1'b0;
            r_hpd_d  <= 1'b0;
        end else begin
            r_hpd_s1 <= i_hpd;
            r_hpd_s2 <= r_hpd_s1;
            r_hpd_d  <= r_hpd_s2;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge i_pt_ck) begin
        if (i_reset) begin
            r_state    <= S_WAIT;
            r_dly_cnt  <= 15'd0;
            r_to_cnt   <= 12'd0;
            r_go_cnt   <= 1'b0;
            r_to_fail  <= 1'b0;
            r_go       <= 1'b0;
            r_reg_data <= 16'h0000;
            r_index    <= 4'd0;
            r_retry    <= 2'd0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_dly_cnt == DLY_LAST) begin
                        r_dly_cnt  <= 15'd0;
                        r_reg_data <= table_entry(r_index);
                        r_state    <= S_LOAD;
                    end else begin
                        r_dly_cnt <= r_dly_cnt + 15'd1;
                    end
                end
                // Never re-trigger an engine that is still busy after a timeout
                S_LOAD: begin
                    r_reg_data <= table_entry(r_index);
                    if (i_end_ok) begin
                        r_go     <= 1'b1;
                        r_go_cnt <= 1'b0;
                        r_state  <= S_GO_HI;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_GO_HI: begin
                    if (r_go_cnt) begin
                        r_go     <= 1'b0;
                        r_to_cnt <= 12'd0;
                        r_state  <= S_GO_LO;
                    end else begin
                        r_go_cnt <= 1'b1;
                    end
                end
                S_GO_LO: begin
                    if (r_to_cnt == TO_LAST) begin
                        r_to_fail <= 1'b1;
                        r_state   <= S_CHECK;
                    end else begin
                        r_to_cnt <= r_to_cnt + 12'd1;
                        if (!i_end_ok) begin
                            r_state <= S_BUSY;
                        end else begin
                            r_state <= S_GO_LO;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_to_cnt == TO_LAST) begin
                        r_to_fail <= 1'b1;
                        r_state   <= S_CHECK;
                    end else begin
                        r_to_cnt <= r_to_cnt + 12'd1;
                        if (i_end_ok) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_CHECK: begin
                    r_to_fail <= 1'b0;
                    if (w_attempt_ok) begin
                        if (r_index == LAST_INDEX) begin
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_index    <= w_next_index;
                            r_retry    <= 2'd0;
                            r_reg_data <= table_entry(w_next_index);
                            r_state    <= S_LOAD;
                        end
                    end else if (r_retry < RETRY_MAX) begin
                        r_retry <= r_retry + 2'd1;
                        r_state <= S_LOAD;
                    end else begin
                        r_error <= 1'b1;
                        r_state <= S_FAIL;
                    end
                end
                S_DONE, S_FAIL: begin
                    if (w_hpd_rise) begin
                        r_ready   <= 1'b0;
                        r_error   <= 1'b0;
                        r_index   <= 4'd0;
                        r_retry   <= 2'd0;
                        r_dly_cnt <= 15'd0;
                        r_state   <= S_WAIT;
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_go    <= 1'b0;
                    r_state <= S_WAIT;
                end
            endcase
        end
    end

    assign o_go            = r_go;
    assign o_slave_address = SLAVE_ADDR;
    assign o_reg_data      = r_reg_data;
    assign o_index         = r_index;
    assign o_retry         = r_retry;
    assign o_ready         = r_ready;
    assign o_error         = r_error;

endmodule
